key_blink_scheduler: RTL
========================

// Module: key_blink_scheduler
// PURPOSE
//  Shares one LED blink engine between NUM_KEYS push keys. Each key's press length is timed
//  and classified into short, mid or long, and a blink request is latched on release.
//  A round-robin scheduler grants the engine to one pending key at a time.
//  The engine toggles led_out N_SHORT, N_MID or N_LONG times.
//  Sits between the debounced key inputs and the board LED, one instance per LED.
// PARAMETERS
//  NUM_KEYS     4            number of requesting keys (2..8)
//  CNT_W        32           width of press-timer and phase counters
//  T_MID        50_000_000   press cycles strictly above this -> mid class
//  T_LONG       100_000_000  press cycles strictly above this -> long class
//  HALF_PERIOD  25_000_000   cycles between led_out toggles (>=2)
//  N_SHORT      10           toggles for short class (even)
//  N_MID        20           toggles for mid class (even)
//  N_LONG       40           toggles for long class (even)
// PORTS
//  clk          in   1         single clock, all logic posedge
//  rst          in   1         synchronous, active-high reset
//  key_in       in   NUM_KEYS  debounced keys, 1 = pressed
//  led_out      out  1         shared LED drive
//  grant_valid  out  1         engine is serving grant_id
//  grant_id     out  IDW       key being served, IDW = $clog2(NUM_KEYS)
//  pending      out  NUM_KEYS  per-key latched request flags
// BEHAVIOUR
//  Reset: all outputs 0, all timers 0, class regs = SHORT, rr_ptr = 0, FSM = IDLE.
//   Takes effect on the next edge, including mid-session.
//  Press timer, per key:
//   - Increments while key_in[k]=1 and saturates at all-ones.
//   - On the falling edge of key_in[k] (registered previous value), the class is computed:
//     cnt>T_LONG -> LONG, else cnt>T_MID -> MID, else SHORT. The compare is strict, so
//     exactly T_MID is SHORT.
//   - The same edge sets pending[k]=1 (visible the next cycle) and clears the timer.
//   - A re-release while pending[k]=1 overwrites the class: latest press wins.
//  Scheduler FSM, states IDLE, BLINK, GAP:
//   - IDLE: if pending != 0, choose the first set bit searching from rr_ptr upward with
//     wrap. At the next edge: grant_valid=1, grant_id=k, pending[k]=0,
//     toggle target = N of k's class, phase=0, toggles=0, rr_ptr=k+1 mod NUM_KEYS,
//     state -> BLINK.
//   - BLINK: phase counts 0..HALF_PERIOD-1. When phase==HALF_PERIOD-1, led_out inverts,
//     phase=0 and toggles+1. The first toggle occurs HALF_PERIOD cycles after grant.
//     When the toggle making toggles==target occurs, state -> GAP.
//   - GAP: exactly one cycle with grant_valid=0 and led_out=0 -> IDLE.
//     Back-to-back sessions are therefore separated by >=2 cycles: GAP plus the IDLE grant.
//  Abort: if key_in[grant_id] rises during BLINK, the session ends at the next edge
//   (led_out=0, -> GAP). The new press is timed normally and re-requests on release.
//  Simultaneous events:
//   - Several releases in one cycle all set pending and are served in RR order.
//   - A release of a key in the same cycle it is granted sets pending again, because the
//     set wins over the grant-clear.
//  led_out is 0 in IDLE and GAP. Since every N is even, led_out ends low after a full session.
//  Presses on non-granted keys never disturb the running session.
// STRUCTURE
//  Shared package key_blink_pkg:
//   - class typedef {CLS_SHORT, CLS_MID, CLS_LONG} (2 bits)
//   - FSM state typedef {ST_IDLE, ST_BLINK, ST_GAP}
//   - function rr_pick(pending, ptr) returning the granted index
//  Sub-module key_press_classifier, instantiated NUM_KEYS times:
//   - inputs: clk, rst, key_in
//   - outputs: release pulse and class
//   - contains the press timer, edge detect and threshold compare
//  The top holds the pending flags, the RR pointer, the FSM and the blink engine.
// TESTING  (NUM_KEYS=4, T_MID=8, T_LONG=16, HALF_PERIOD=4, N_SHORT=2, N_MID=4, N_LONG=8)
//  1. Key0 held 5 cycles, then released:
//     - pending=0001, then grant_id=0.
//     - led_out toggles 4 and 8 cycles after grant, then GAP, then IDLE with led_out=0.
//  2. Key1 held exactly 8 cycles -> SHORT (2 toggles); held 9 -> MID (4 toggles);
//     held 17 -> LONG (8 toggles).
//  3. Keys 2 and 0 released in the same cycle with rr_ptr=1 -> key2 served first,
//     key0 served after the 1-cycle GAP, and rr_ptr=1 at the end.
//  4. Key3 re-pressed during its own BLINK after 1 toggle:
//     - next edge: led_out=0, grant_valid=0.
//     - re-release as MID -> a 4-toggle session follows.
//  5. rst=1 for 1 cycle mid-LONG session with key1 pending:
//     - next edge: all outputs 0, pending=0000.
//     - no further toggles until a new release.
//  6. Key0 held 2^CNT_W+5 cycles (use CNT_W=5) -> timer saturates, class LONG,
//     no wrap to SHORT.

Source files
------------

// File: rtl/key_blink_pkg.sv
// Shared types and the round-robin pick helper for the key blink scheduler.
package key_blink_pkg;

    localparam int unsigned MAX_KEYS = 8;
    localparam int unsigned MAX_IDW  = 3;

    typedef enum logic [1:0] {
        CLS_SHORT = 2'd0,
        CLS_MID   = 2'd1,
        CLS_LONG  = 2'd2
    } cls_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLINK = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // First set bit of pend searching upward from ptr, wrapping at num_keys.
    function automatic logic [MAX_IDW-1:0] rr_pick(
        input logic [MAX_KEYS-1:0] pend,
        input logic [MAX_IDW-1:0]  ptr,
        input int unsigned         num_keys
    );
        logic [MAX_IDW-1:0] pick;
        logic               found;
        int unsigned        idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_KEYS; i++) begin
            if (i < num_keys) begin
                idx = 32'(ptr) + i;
                if (idx >= num_keys) begin
                    idx = idx - num_keys;
                end
                if (!found && pend[idx[MAX_IDW-1:0]]) begin
                    pick  = idx[MAX_IDW-1:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/key_press_classifier.sv
// Times one key's press and classifies it as short/mid/long on release.
module key_press_classifier
    import key_blink_pkg::*;
#(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned T_MID  = 50_000_000,
    parameter int unsigned T_LONG = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic release_c,
    output logic press_c,
    output cls_e cls_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             key_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cls_e             cls_q, cls_d;

    assign release_c = key_q & ~key_in;
    assign press_c   = key_in & ~key_q;
    assign cls_o     = cls_q;

    // Saturating press timer; classify and clear on release.
    always_comb begin
        cnt_d = cnt_q;
        cls_d = cls_q;
        if (release_c) begin
            cnt_d = '0;
            if (cnt_q > CNT_W'(T_LONG)) begin
                cls_d = CLS_LONG;
            end else if (cnt_q > CNT_W'(T_MID)) begin
                cls_d = CLS_MID;
            end else begin
                cls_d = CLS_SHORT;
            end
        end else if (key_in && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Timer, class and previous-key registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= 1'b0;
            cnt_q <= '0;
            cls_q <= CLS_SHORT;
        end else begin
            key_q <= key_in;
            cnt_q <= cnt_d;
            cls_q <= cls_d;
        end
    end

endmodule

// File: rtl/key_blink_scheduler.sv
// Round-robin sharing of one LED blink engine between several keys.
module key_blink_scheduler
    import key_blink_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned T_MID       = 50_000_000,
    parameter int unsigned T_LONG      = 100_000_000,
    parameter int unsigned HALF_PERIOD = 25_000_000,
    parameter int unsigned N_SHORT     = 10,
    parameter int unsigned N_MID       = 20,
    parameter int unsigned N_LONG      = 40,
    localparam int unsigned IDW        = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic                led_out,
    output logic                grant_valid,
    output logic [IDW-1:0]      grant_id,
    output logic [NUM_KEYS-1:0] pending
);

    logic [NUM_KEYS-1:0] release_c;
    logic [NUM_KEYS-1:0] press_c;
    cls_e                cls [NUM_KEYS];

    state_e              state_q, state_d;
    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic [IDW-1:0]      rr_q, rr_d;
    logic [IDW-1:0]      gid_q, gid_d;
    logic                gv_q, gv_d;
    logic                led_q, led_d;
    logic [CNT_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]    tog_q, tog_d;
    logic [CNT_W-1:0]    target_q, target_d;
    logic [IDW-1:0]      pick_c;

    // Toggle count for a press class.
    function automatic logic [CNT_W-1:0] n_of(input cls_e c);
        case (c)
            CLS_LONG: n_of = CNT_W'(N_LONG);
            CLS_MID:  n_of = CNT_W'(N_MID);
            default:  n_of = CNT_W'(N_SHORT);
        endcase
    endfunction

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_press_classifier #(
            .CNT_W  (CNT_W),
            .T_MID  (T_MID),
            .T_LONG (T_LONG)
        ) u_cls (
            .clk       (clk),
            .rst       (rst),
            .key_in    (key_in[g]),
            .release_c (release_c[g]),
            .press_c   (press_c[g]),
            .cls_o     (cls[g])
        );
    end

    assign led_out     = led_q;
    assign grant_valid = gv_q;
    assign grant_id    = gid_q;
    assign pending     = pending_q;

    // Scheduler FSM and blink engine next-state.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        rr_d      = rr_q;
        gid_d     = gid_q;
        gv_d      = gv_q;
        led_d     = led_q;
        phase_d   = phase_q;
        tog_d     = tog_q;
        target_d  = target_q;
        pick_c    = IDW'(rr_pick(MAX_KEYS'(pending_q), MAX_IDW'(rr_q), NUM_KEYS));

        case (state_q)
            ST_IDLE: begin
                led_d = 1'b0;
                gv_d  = 1'b0;
                if (|pending_q) begin
                    state_d           = ST_BLINK;
                    gv_d              = 1'b1;
                    gid_d             = pick_c;
                    pending_d[pick_c] = 1'b0;
                    target_d          = n_of(cls[pick_c]);
                    phase_d           = '0;
                    tog_d             = '0;
                    rr_d              = (pick_c == IDW'(NUM_KEYS - 1)) ? '0 : pick_c + IDW'(1);
                end
            end
            ST_BLINK: begin
                if (press_c[gid_q]) begin
                    state_d = ST_GAP;
                    gv_d    = 1'b0;
                    led_d   = 1'b0;
                end else if (phase_q == CNT_W'(HALF_PERIOD - 1)) begin
                    led_d   = ~led_q;
                    phase_d = '0;
                    tog_d   = tog_q + CNT_W'(1);
                    if (tog_d == target_q) begin
                        state_d = ST_GAP;
                        gv_d    = 1'b0;
                    end
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                gv_d    = 1'b0;
                led_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                gv_d    = 1'b0;
                led_d   = 1'b0;
            end
        endcase

        // A release in the grant cycle re-arms the flag.
        pending_d = pending_d | release_c;
    end

    // State and engine registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            rr_q      <= '0;
            gid_q     <= '0;
            gv_q      <= 1'b0;
            led_q     <= 1'b0;
            phase_q   <= '0;
            tog_q     <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            gid_q     <= gid_d;
            gv_q      <= gv_d;
            led_q     <= led_d;
            phase_q   <= phase_d;
            tog_q     <= tog_d;
            target_q  <= target_d;
        end
    end

endmodule
